// File: rtl/colour_pkg.sv
// colour_pkg
//   Shared definitions for the RGB <-> colour-index converters:
//   - palette geometry (ENTRIES, IDX_W, RGB_W)
//   - default palette constants, RGB packed as {R[23:16], G[15:8], B[7:0]}
//   - FSM state encoding of the reverse lookup
//   - default_colour(): reset contents of one palette entry
package colour_pkg;

   localparam int ENTRIES = 8;
   localparam int IDX_W   = 3;
   localparam int RGB_W   = 24;

   localparam logic [RGB_W-1:0] COL_BLACK   = 24'h000000;
   localparam logic [RGB_W-1:0] COL_BLUE    = 24'h0000FF;
   localparam logic [RGB_W-1:0] COL_GREEN   = 24'h00FF00;
   localparam logic [RGB_W-1:0] COL_CYAN    = 24'h00FFFF;
   localparam logic [RGB_W-1:0] COL_RED     = 24'hFF0000;
   localparam logic [RGB_W-1:0] COL_MAGENTA = 24'hFF00FF;
   localparam logic [RGB_W-1:0] COL_YELLOW  = 24'hFFFF00;
   localparam logic [RGB_W-1:0] COL_WHITE   = 24'hFFFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index bit 2 drives red, bit 1 green, bit 0 blue.
   function automatic logic [RGB_W-1:0] default_colour(input logic [IDX_W-1:0] idx);
      logic [RGB_W-1:0] w_rgb;
      case (idx)
         3'd0:    w_rgb = COL_BLACK;
         3'd1:    w_rgb = COL_BLUE;
         3'd2:    w_rgb = COL_GREEN;
         3'd3:    w_rgb = COL_CYAN;
         3'd4:    w_rgb = COL_RED;
         3'd5:    w_rgb = COL_MAGENTA;
         3'd6:    w_rgb = COL_YELLOW;
         default: w_rgb = COL_WHITE;
      endcase
      return w_rgb;
   endfunction

endpackage

// File: rtl/colour_table.sv
// colour_table
//   8 x 24-bit palette register file.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset (loads default palette)
//     wr_en           write strobe
//     wr_addr[2:0]    entry written at the rising edge
//     wr_data[23:0]   RGB value stored
//     rd_addr[2:0]    combinational read address
//     rd_data[23:0]   contents of entry rd_addr (pre-edge value during a write)
module colour_table
   import colour_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [RGB_W-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [RGB_W-1:0] rd_data
);

   logic [RGB_W-1:0] r_mem [ENTRIES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_mem[i] <= default_colour(IDX_W'(i));
         end
      end else if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Read is combinational, so a compare in the same cycle as a write
   // to that entry sees the old value.
   assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/rgb_to_colour.sv
// rgb_to_colour
//   Reverse colour lookup: scans the 8-entry palette from index 0 upward
//   and returns the lowest index whose RGB value exactly equals the request.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     wr_en/wr_addr/wr_data    palette write port (legal in any state)
//     in_valid/in_ready/rgb    lookup request
//     out_valid/out_ready      result handshake
//     colour[2:0], hit         result: matched index, 1 = match found
//     dbg_state                current FSM state (observation only)
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both high; ready is only meaningful while the partner's valid is
//   high, and a held result stays stable until it is taken.
module rgb_to_colour
   import colour_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [RGB_W-1:0] wr_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RGB_W-1:0] rgb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] colour,
   output logic             hit,
   output state_t           dbg_state
);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [RGB_W-1:0] r_hold;
   logic [IDX_W-1:0] r_colour;
   logic             r_hit;

   state_t           w_next_state;
   logic [IDX_W-1:0] w_next_idx;
   logic [RGB_W-1:0] w_next_hold;
   logic [IDX_W-1:0] w_next_colour;
   logic             w_next_hit;
   logic [RGB_W-1:0] w_entry;
   logic             w_match;

   colour_table u_table (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (r_idx),
      .rd_data (w_entry)
   );

   assign w_match = (w_entry == r_hold);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_hold   <= '0;
         r_colour <= '0;
         r_hit    <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_idx    <= w_next_idx;
         r_hold   <= w_next_hold;
         r_colour <= w_next_colour;
         r_hit    <= w_next_hit;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_idx    = r_idx;
      w_next_hold   = r_hold;
      w_next_colour = r_colour;
      w_next_hit    = r_hit;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_next_hold  = rgb;
               w_next_idx   = '0;
               w_next_state = SCAN;
            end
         end
         SCAN: begin
            // Ascending scan with early exit gives lowest-index-wins.
            if (w_match) begin
               w_next_colour = r_idx;
               w_next_hit    = 1'b1;
               w_next_state  = DONE;
            end else if (r_idx == IDX_W'(ENTRIES - 1)) begin
               w_next_colour = '0;
               w_next_hit    = 1'b0;
               w_next_state  = DONE;
            end else begin
               w_next_idx = r_idx + 3'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign colour    = r_colour;
   assign hit       = r_hit;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_rgb_to_colour.sv
module tb_rgb_to_colour;
   import colour_pkg::*;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [23:0] wr_data;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] rgb;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  colour;
   logic        hit;
   state_t      dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] exp_q[$];   // {colour, hit}

   rgb_to_colour dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rgb       (rgb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .colour    (colour),
      .hit       (hit),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pal_write(input logic [2:0] a, input logic [23:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // One lookup. e_cyc counts cycles from the accept edge through the edge
   // that raises out_valid (2 for index 0, 9 for a miss). wr_at >= 0 drives
   // a palette write during the cycle k edges after the accept (k = scan idx).
   task automatic lookup(input string tag, input logic [23:0] rgb_v,
                         input logic [2:0] e_col, input logic e_hit,
                         input int e_cyc, input int hold, input int wr_at,
                         input logic [2:0] wa, input logic [23:0] wd);
      int k;
      bit seen;
      logic [3:0] exp_v;
      @(negedge clk);
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      rgb = rgb_v;
      exp_q.push_back({e_col, e_hit});
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      seen = 0;
      while (!seen && k <= 20) begin
         if (out_valid) begin
            seen = 1;
         end else begin
            wr_en   = (k == wr_at);
            wr_addr = wa;
            wr_data = wd;
            @(negedge clk);
            k++;
         end
      end
      wr_en = 1'b0;
      if (!seen) begin
         check({tag, " timeout"}, 32'(out_valid), 32'd1);
         return;
      end
      check({tag, " latency"}, 32'(k + 1), 32'(e_cyc));
      for (int h = 0; h < hold; h++) begin
         check({tag, " hold colour"}, 32'(colour), 32'(e_col));
         check({tag, " hold hit"}, 32'(hit), 32'(e_hit));
         check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
         check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
         @(negedge clk);
      end
      if (exp_q.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'd0, 32'd1);
         return;
      end
      exp_v = exp_q.pop_front();
      check({tag, " colour"}, 32'(colour), 32'(exp_v[3:1]));
      check({tag, " hit"}, 32'(hit), 32'(exp_v[0]));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      bit spurious;
      rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      in_valid = 1'b0; rgb = '0; out_ready = 1'b0;
      #12;
      // reset state
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst colour", 32'(colour), 32'd0);
      check("rst hit", 32'(hit), 32'd0);
      check("rst state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;

      // default palette
      lookup("green", 24'h00FF00, 3'd2, 1'b1, 4, 0, -1, 3'd0, 24'h0);
      lookup("black", 24'h000000, 3'd0, 1'b1, 2, 0, -1, 3'd0, 24'h0);
      lookup("miss", 24'h123456, 3'd0, 1'b0, 9, 0, -1, 3'd0, 24'h0);

      // reprogram / duplicates
      pal_write(3'd5, 24'h0000FF);
      lookup("dup low", 24'h0000FF, 3'd1, 1'b1, 3, 0, -1, 3'd0, 24'h0);
      pal_write(3'd1, 24'h000000);
      lookup("dup after", 24'h0000FF, 3'd5, 1'b1, 7, 0, -1, 3'd0, 24'h0);

      // backpressure
      lookup("white bp", 24'hFFFFFF, 3'd7, 1'b1, 9, 5, -1, 3'd0, 24'h0);

      // write during scan, ahead of the scan pointer
      do_reset();
      lookup("wr ahead", 24'hABCDEF, 3'd6, 1'b1, 8, 0, 2, 3'd6, 24'hABCDEF);
      // write during scan, behind the scan pointer
      do_reset();
      lookup("wr behind", 24'hABCDEF, 3'd0, 1'b0, 9, 0, 2, 3'd1, 24'hABCDEF);

      // reset mid-scan, after reprogramming entry 4
      pal_write(3'd4, 24'h000001);
      @(negedge clk);
      in_valid = 1'b1;
      rgb = 24'h123456;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd1);
      check("abort colour", 32'(colour), 32'd0);
      check("abort hit", 32'(hit), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      spurious = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) spurious = 1;
      end
      check("abort no result", 32'(spurious), 32'd0);
      lookup("red restored", 24'hFF0000, 3'd4, 1'b1, 6, 0, -1, 3'd0, 24'h0);
      lookup("blue restored", 24'h0000FF, 3'd1, 1'b1, 3, 0, -1, 3'd0, 24'h0);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
